alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Round-robin scheduler that shares the single alu instance between NREQ independent requesters.
- Accepts one operation (app, sel, a, b) per grant, issues a one-cycle en pulse to the alu and waits for done.
- Returns the 160-bit result to the granted requester over a valid/ready response channel.
- Sits between requester logic (collector-style front ends) and the alu. A watchdog prevents a hung alu from blocking the arbiter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 80, operand width of a and b.
- CW, 160, result width of c.
- TIMEOUT, 1024, max cycles waited for alu done before an error response is returned.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester operation request.
- req_ready  output  NREQ  one-hot acceptance pulse; request i is consumed when req_valid[i] & req_ready[i].
- req_app  input  NREQ*3  op code, requester i at bits [3i+2:3i].
- req_sel  input  NREQ  sub-op select per requester.
- req_a  input  NREQ*AW  operand a, requester i at [AW*i+AW-1:AW*i].
- req_b  input  NREQ*AW  operand b, same packing as req_a.
- rsp_valid  output  NREQ  one-hot result valid toward the granted requester.
- rsp_ready  input  NREQ  result accept per requester.
- rsp_c  output  CW  result data, shared by all requesters.
- rsp_err  output  1  qualifies rsp_valid; 1 = timeout, rsp_c is zero.
- alu_en  output  1  one-cycle start pulse to the alu.
- alu_app  output  3  latched op code.
- alu_sel  output  1  latched select.
- alu_a  output  AW  latched operand a.
- alu_b  output  AW  latched operand b.
- alu_c  input  CW  alu result.
- alu_done  input  1  alu completion strobe.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  3  index of the current or last granted requester.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer 0 (requester 0 has highest priority); watchdog 0. Reset mid-operation abandons the op. A late alu_done after reset is ignored.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching from pointer upward with wrap modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On that edge: latch app/sel/a/b of g into alu_* registers; grant_id <= g; pointer <= (g+1) mod NREQ; go to ISSUE.
  - With no req_valid, stay in IDLE and keep the pointer.
- ISSUE: alu_en=1 for exactly this cycle; watchdog cleared; go to WAIT. alu_done in this cycle is ignored.
- WAIT:
  - alu_en=0; alu_* operand outputs hold stable from ISSUE through WAIT.
  - On alu_done=1: rsp_c <= alu_c, rsp_err <= 0, go to RESP.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1 without done: rsp_c <= 0, rsp_err <= 1, go to RESP.
  - done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid[grant_id]=1; rsp_c and rsp_err are held until rsp_ready[grant_id]=1.
  - On acceptance, rsp_valid drops on the next edge and the state returns to IDLE.
  - rsp_ready bits of other requesters are ignored. alu_done in RESP or IDLE is ignored.
- No new request is granted while busy=1; req_ready is 0 outside IDLE.
- Minimum cycles from acceptance to rsp_valid: 3 (accept edge, ISSUE, done in first WAIT cycle).
- Fairness: a continuously requesting requester waits at most NREQ-1 other grants.

Test Plan:
- Single op: req_valid=0001, app=3'd1, a=5, b=7, alu model done 2 cycles after en, c=12 -> req_ready=0001 that cycle; one alu_en pulse with alu_a=5, alu_b=7; rsp_valid=0001, rsp_c=12, rsp_err=0; then busy=0.
- Simultaneous: req_valid=1111 held from reset -> grant order 0,1,2,3,0; grant_id follows that sequence; exactly one alu_en per grant.
- Pointer wrap: after a grant to 3, requesters 1 and 3 both valid -> grant 1, then 3.
- Backpressure: rsp_ready held 0 for 10 cycles in RESP -> rsp_valid and rsp_c stay stable; req_valid[2]=1 meanwhile gets no req_ready; serviced only after rsp_ready=1.
- Timeout: TIMEOUT=16, alu_done never asserted -> rsp_valid 16 cycles after the start of WAIT, rsp_err=1, rsp_c=0. A done pulse injected afterwards is ignored; the next request proceeds normally.
- Reset mid-WAIT: rst=1 for one cycle during WAIT -> all outputs 0 on the next edge; a following alu_done produces no rsp_valid; the pointer restarts at 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Purpose : round-robin arbiter sharing one alu between NREQ requesters, with a done watchdog.
// Latency : request accept -> rsp_valid in 3 cycles minimum (accept edge, ISSUE, done in first WAIT cycle).
// Backpr. : one op in flight; req_ready stays 0 until the response is taken via rsp_ready[grant_id].
//
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   req_valid/req_ready            per-requester op handshake; req_ready is a one-hot pulse in IDLE
//   req_app/req_sel/req_a/req_b    per-requester op fields, requester i packed at slice i
//   rsp_valid/rsp_ready            one-hot response handshake toward the granted requester
//   rsp_c, rsp_err                 shared result bus; rsp_err=1 means watchdog expiry and rsp_c=0
//   alu_en/alu_app/alu_sel/alu_a/alu_b, alu_c/alu_done   alu start pulse, latched op, result
//   busy, grant_id                 not-IDLE flag, current or last granted requester
module alu_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 80,
    parameter int CW      = 160,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*3-1:0]    req_app,
    input  logic [NREQ-1:0]      req_sel,
    input  logic [NREQ*AW-1:0]   req_a,
    input  logic [NREQ*AW-1:0]   req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [CW-1:0]        rsp_c,
    output logic                 rsp_err,
    output logic                 alu_en,
    output logic [2:0]           alu_app,
    output logic                 alu_sel,
    output logic [AW-1:0]        alu_a,
    output logic [AW-1:0]        alu_b,
    input  logic [CW-1:0]        alu_c,
    input  logic                 alu_done,
    output logic                 busy,
    output logic [2:0]           grant_id
);

    // Sized to hold TIMEOUT-1 for any TIMEOUT >= 1.
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [2:0]    app;
        logic          sel;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
    } op_t;

    state_t          state, state_nxt;
    logic [2:0]      ptr;
    logic [WDW-1:0]  wd;
    op_t             op_q, op_sel;

    logic [NREQ-1:0] vld_rot;
    logic            gnt_vld;
    logic [2:0]      gnt_off;
    logic [3:0]      gnt_sum;
    logic [2:0]      gnt;
    logic            wd_expired;
    logic            rsp_acc;

    // Round-robin pick: rotate req_valid so the pointer lands on bit 0, take the
    // lowest set bit, then add the pointer back modulo NREQ.
    always_comb begin
        vld_rot = NREQ'({req_valid, req_valid} >> ptr);
        gnt_vld = 1'b0;
        gnt_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (vld_rot[k]) begin
                gnt_vld = 1'b1;
                gnt_off = 3'(k);
            end
        end
        gnt_sum = {1'b0, ptr} + {1'b0, gnt_off};
        if (gnt_sum >= 4'(NREQ)) begin
            gnt_sum = gnt_sum - 4'(NREQ);
        end
        gnt = gnt_sum[2:0];
    end

    always_comb begin
        op_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == 3'(i)) begin
                op_sel.app = req_app[3*i +: 3];
                op_sel.sel = req_sel[i];
                op_sel.a   = req_a[AW*i +: AW];
                op_sel.b   = req_b[AW*i +: AW];
            end
        end
    end

    // Watchdog counts WAIT cycles from 0; expiry on its last value gives exactly
    // TIMEOUT WAIT cycles before an error response.
    assign wd_expired = (wd == WDW'(TIMEOUT - 1));
    assign rsp_acc    = |((NREQ'(1) << grant_id) & rsp_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        alu_en    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                // Gated by rst so a request seen during reset is not consumed.
                if (gnt_vld && !rst) begin
                    req_ready = NREQ'(1) << gnt;
                end
                if (gnt_vld) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                alu_en    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (alu_done || wd_expired) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = NREQ'(1) << grant_id;
                if (rsp_acc) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            grant_id <= '0;
            op_q     <= '0;
            wd       <= '0;
            rsp_c    <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        op_q     <= op_sel;
                        grant_id <= gnt;
                        ptr      <= (gnt == 3'(NREQ - 1)) ? 3'd0 : gnt + 3'd1;
                    end
                end
                ISSUE: begin
                    wd <= '0;
                end
                WAIT: begin
                    // done has priority over a simultaneous watchdog expiry
                    if (alu_done) begin
                        rsp_c   <= alu_c;
                        rsp_err <= 1'b0;
                    end else if (wd_expired) begin
                        rsp_c   <= '0;
                        rsp_err <= 1'b1;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_app = op_q.app;
    assign alu_sel = op_q.sel;
    assign alu_a   = op_q.a;
    assign alu_b   = op_q.b;

endmodule
